pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameters: MEM_TIMEOUT, default 255, the consecutive memory-wait cycles before the timeout flag sets; STALL_CNT_W, default 16, the stall counter width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: id_rs1, id_rs2  in  5 (reg_addr_t)  source registers of the instruction in ID.
REQ-005 SHALL have ports: id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2.
REQ-006 SHALL have ports: ex_rd  in  5; ex_mem_read  in  1  load in EX.
REQ-007 SHALL have ports: mem_req  in  1; mem_ready  in  1  data-memory handshake for the op in MEM.
REQ-008 SHALL have ports: ex_muldiv_start  in  1; muldiv_done  in  1  (level, held until EX advances).
REQ-009 SHALL have ports: ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-010 SHALL have ports: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold registers.
REQ-011 SHALL have ports: if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1  insert NOP.
REQ-012 SHALL have ports: ctrl_state  out  2  00 RUN, 01 MEM_WAIT, 10 MULDIV_WAIT.
REQ-013 SHALL have ports: mem_timeout  out  1 sticky; stall_cycles  out  STALL_CNT_W.

Function
REQ-014 SHALL decode mem_stall = mem_req && !mem_ready.
REQ-015 SHALL decode load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-016 SHALL decode muldiv_hold = !muldiv_done && (ex_muldiv_start || ctrl_state==MULDIV_WAIT).
REQ-017 SHALL drive stall/bubble outputs combinationally in the same cycle, using the highest-priority rule that applies; every output not named by that rule is 0.
REQ-018 Priority 1, mem_stall SHALL assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble.
REQ-019 Priority 2, muldiv_hold SHALL assert pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble.
REQ-020 Priority 3, ex_redirect SHALL assert if_id_bubble and id_ex_bubble (flush); redirect SHALL be suppressed while mem_stall or muldiv_hold is active.
REQ-021 Priority 4, load_use SHALL assert pc_stall, if_id_stall and id_ex_bubble for exactly one cycle per hazard.
REQ-022 With no rule active, all stall/bubble outputs SHALL be 0.
REQ-023 ctrl_state next-state SHALL be MEM_WAIT if mem_stall, else MULDIV_WAIT if muldiv_hold, else RUN.
REQ-024 On return from MEM_WAIT to a still-busy multiply/divide, the next state SHALL be MULDIV_WAIT.
REQ-025 If muldiv_done is high in the ex_muldiv_start cycle, no stall SHALL occur and the state SHALL stay RUN.
REQ-026 A mem_wait counter (8 bits minimum) SHALL increment each mem_stall cycle and clear on any non-mem_stall cycle.
REQ-027 When the mem_wait counter reaches MEM_TIMEOUT, mem_timeout SHALL set and hold until reset; the stall SHALL continue.
REQ-028 stall_cycles SHALL increment each cycle pc_stall=1 and saturate at all-ones, with no wrap.
REQ-029 Simultaneous ex_redirect and ex_muldiv_start is illegal; the bench SHALL flag it, and RTL SHALL apply priority 2.

Reset
REQ-030 While rst=1, all stall/bubble outputs SHALL be 0 and ctrl_state SHALL be RUN.
REQ-031 While rst=1, the mem_wait counter, stall_cycles and mem_timeout SHALL be 0.
REQ-032 Reset asserted mid-MEM_WAIT or mid-MULDIV_WAIT SHALL return all state to reset values asynchronously.
REQ-033 The first edge after rst deasserts SHALL evaluate normally.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_bubble=1 that cycle only, stall_cycles=1.
REQ-035 ex_rd=0 with id_rs1=0 -> no stall.
REQ-036 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> four stalls plus mem_wb_bubble for 3 cycles, ctrl_state=MEM_WAIT on cycles 2-3, RUN after.
REQ-037 Multiply/divide: start, done after 4 cycles -> stalls plus ex_mem_bubble for 4 cycles, MULDIV_WAIT, cleared in the done cycle.
REQ-038 MEM_WAIT during MULDIV_WAIT: mem_stall for 2 cycles -> ex_mem_stall=1, mem_wb_bubble=1, then MULDIV_WAIT resumes.
REQ-039 Redirect: ex_redirect=1 with load_use=1 -> if_id_bubble=id_ex_bubble=1, pc_stall=0.
REQ-040 Redirect during mem_stall -> no flush until mem_ready=1.
REQ-041 Timeout and reset: MEM_TIMEOUT=4, mem_ready=0 for 6 cycles -> mem_timeout=1 from the 4th wait cycle; rst pulse -> mem_timeout=0, ctrl_state=RUN, stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Decodes three stall sources and one flush source, then drives the per-stage
// hold/bubble controls by fixed priority:
//   1. data-memory wait  (mem_req && !mem_ready)
//   2. multiply/divide   (EX unit busy, muldiv_done low)
//   3. control redirect  (taken branch/jump resolved in EX)
//   4. load-use hazard   (ID reads the register a load in EX will write)
// Stall/bubble outputs are combinational so they act in the cycle the
// condition appears. All of them are forced low while rst is high.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   id_rs1, id_rs2                source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2      ID instruction actually reads rs1 / rs2
//   ex_rd, ex_mem_read            destination register / load flag of EX op
//   mem_req, mem_ready            data-memory handshake for the MEM op
//   ex_muldiv_start, muldiv_done  mul/div issued in EX, result available
//   ex_redirect                   taken branch/jump in EX
//   *_stall                       hold the named pipeline register
//   *_bubble                      load a NOP into the named pipeline register
//   ctrl_state                    00 RUN, 01 MEM_WAIT, 10 MULDIV_WAIT
//   mem_timeout                   sticky: memory wait reached MEM_TIMEOUT cycles
//   stall_cycles                  saturating count of cycles with pc_stall high
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   ex_muldiv_start,
  input  logic                   muldiv_done,
  input  logic                   ex_redirect,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   ex_mem_stall,
  output logic                   if_id_bubble,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic                   mem_wb_bubble,
  output logic [1:0]             ctrl_state,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_MEM_WAIT    = 2'b01,
    ST_MULDIV_WAIT = 2'b10
  } state_t;

  // Memory-wait counter is at least 8 bits, wider if the timeout needs it.
  localparam int MW_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int MW_W   = (MW_RAW > 8) ? MW_RAW : 8;
  localparam logic [MW_W:0] TIMEOUT_V = (MW_W+1)'(MEM_TIMEOUT);

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   md_busy_r;
  logic [MW_W-1:0]        wait_cnt_r;
  logic                   timeout_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic                   mem_stall_s;
  logic                   load_use_s;
  logic                   muldiv_hold_s;
  logic                   redirect_s;
  logic [MW_W:0]          wait_cnt_nx_s;
  logic                   timeout_hit_s;

  // Hazard decode, gated off while in reset so every output is quiet.
  // md_busy_r keeps an in-flight mul/div visible across a MEM_WAIT detour,
  // where ctrl_state no longer shows MULDIV_WAIT.
  always_comb begin
    mem_stall_s   = 1'b0;
    load_use_s    = 1'b0;
    muldiv_hold_s = 1'b0;
    redirect_s    = 1'b0;
    if (rst) begin
      mem_stall_s   = 1'b0;
    end else begin
      mem_stall_s   = mem_req && !mem_ready;
      load_use_s    = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
      muldiv_hold_s = !muldiv_done &&
                      (ex_muldiv_start || (state_r == ST_MULDIV_WAIT) || md_busy_r);
      redirect_s    = ex_redirect;
    end
  end

  // Priority resolution of stall/bubble controls and FSM next state.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    state_nx_s    = ST_RUN;
    if (mem_stall_s) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
      state_nx_s    = ST_MEM_WAIT;
    end else if (muldiv_hold_s) begin
      // Also covers an (illegal) redirect in the same cycle: the mul/div wins.
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_bubble = 1'b1;
      state_nx_s    = ST_MULDIV_WAIT;
    end else if (redirect_s) begin
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use_s) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else begin
      state_nx_s    = ST_RUN;
    end
  end

  // Timeout fires in the wait cycle whose count (including itself) reaches
  // MEM_TIMEOUT, then the registered copy holds it until reset.
  always_comb begin
    wait_cnt_nx_s = {1'b0, wait_cnt_r} + {{MW_W{1'b0}}, 1'b1};
    timeout_hit_s = mem_stall_s && (wait_cnt_nx_s >= TIMEOUT_V);
  end

  assign ctrl_state   = state_r;
  assign mem_timeout  = timeout_r | timeout_hit_s;
  assign stall_cycles = stall_cnt_r;

  // FSM state and mul/div in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      md_busy_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      md_busy_r <= muldiv_hold_s;
    end
  end

  // Consecutive memory-wait counter (saturating) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {MW_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      if (mem_stall_s) begin
        if (wait_cnt_r != {MW_W{1'b1}}) begin
          wait_cnt_r <= wait_cnt_nx_s[MW_W-1:0];
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= {MW_W{1'b0}};
      end
      timeout_r <= timeout_r | timeout_hit_s;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (pc_stall && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle vector table plus hand-written
// multi-cycle sequences. Inputs change on the falling edge, outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_pipeline_ctrl;

  localparam logic [7:0] P_NONE = 8'b0000_0000;
  localparam logic [7:0] P_MEM  = 8'b1111_0001;
  localparam logic [7:0] P_MD   = 8'b1110_0010;
  localparam logic [7:0] P_RD   = 8'b0000_1100;
  localparam logic [7:0] P_LU   = 8'b1100_0100;
  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_MEM  = 2'b01;
  localparam logic [1:0] S_MD   = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic       mem_req, mem_ready, ex_muldiv_start, muldiv_done, ex_redirect;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic [1:0] ctrl_state;
  logic       mem_timeout;
  logic [3:0] stall_cycles;
  logic [7:0] outs;

  int n_vec = 0;
  int n_bad = 0;
  int n_illegal = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       req;
    logic       rdy;
    logic       start;
    logic       done;
    logic       redir;
    logic [7:0] exp_o;
    logic [1:0] exp_nx;
  } vec_t;

  vec_t vecs [17];

  pipeline_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .ex_muldiv_start(ex_muldiv_start), .muldiv_done(muldiv_done),
    .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble};

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    ex_muldiv_start = 1'b0; muldiv_done = 1'b0; ex_redirect = 1'b0;
  endtask

  // Reset with busy-looking inputs applied; outputs must still be quiet.
  task automatic do_reset(input bit check_it);
    @(negedge clk);
    set_idle();
    mem_req = 1'b1; ex_redirect = 1'b1; ex_muldiv_start = 1'b1;
    rst = 1'b1;
    #1;
    if (check_it) begin
      chk("rst_outs", 16'(outs), 16'(P_NONE));
      chk("rst_state", 16'(ctrl_state), 16'(S_RUN));
      chk("rst_tmo", 16'(mem_timeout), 16'd0);
      chk("rst_stallcnt", 16'(stall_cycles), 16'd0);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    //           rs1    rs2    u1    u2    rd     mr    req   rdy   start done  redir exp_o   exp_nx
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};
    vecs[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_LU,   S_RUN};
    vecs[2]  = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_LU,   S_RUN};
    vecs[3]  = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};
    vecs[4]  = '{5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};
    vecs[5]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};
    vecs[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_MEM,  S_MEM};
    vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};
    vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MD,   S_MD};
    vecs[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_NONE, S_RUN};
    vecs[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_RD,   S_RUN};
    vecs[11] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_RD,   S_RUN};
    vecs[12] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_MEM,  S_MEM};
    vecs[13] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, P_MD,   S_MD};
    vecs[14] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_MEM,  S_MEM};
    vecs[15] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MD,   S_MD};
    vecs[16] = '{5'd4,  5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, S_RUN};

    do_reset(1'b1);

    // Table: one vector cycle, then an idle cycle (muldiv_done high to
    // retire any mul/div) where the state reached is checked.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
      mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
      ex_muldiv_start = vecs[i].start; muldiv_done = vecs[i].done;
      ex_redirect = vecs[i].redir;
      if (vecs[i].redir && vecs[i].start) begin
        n_illegal++;
        $display("note: vector %0d drives illegal ex_redirect with ex_muldiv_start", i);
      end
      #1 chk($sformatf("vec%0d_out", i), 16'(outs), 16'(vecs[i].exp_o));
      @(negedge clk);
      set_idle();
      muldiv_done = 1'b1;
      #1 chk($sformatf("vec%0d_state", i), 16'(ctrl_state), 16'(vecs[i].exp_nx));
    end

    // Load-use for one cycle.
    do_reset(1'b0);
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1 chk("lu_out", 16'(outs), 16'(P_LU));
    @(negedge clk);
    set_idle();
    #1 chk("lu_release", 16'(outs), 16'(P_NONE));
    chk("lu_stallcnt", 16'(stall_cycles), 16'd1);

    // Memory wait of three cycles.
    do_reset(1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      set_idle(); mem_req = 1'b1;
      #1 chk($sformatf("memw%0d_out", k), 16'(outs), 16'(P_MEM));
      chk($sformatf("memw%0d_state", k), 16'(ctrl_state), (k == 1) ? 16'(S_RUN) : 16'(S_MEM));
      chk($sformatf("memw%0d_tmo", k), 16'(mem_timeout), 16'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("memw_ready_out", 16'(outs), 16'(P_NONE));
    @(negedge clk);
    set_idle();
    #1 chk("memw_end_state", 16'(ctrl_state), 16'(S_RUN));
    chk("memw_stallcnt", 16'(stall_cycles), 16'd3);

    // Multiply/divide, done arrives on the fifth cycle.
    do_reset(1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_idle(); ex_muldiv_start = (k == 1);
      #1 chk($sformatf("md%0d_out", k), 16'(outs), 16'(P_MD));
      if (k > 1) chk($sformatf("md%0d_state", k), 16'(ctrl_state), 16'(S_MD));
    end
    @(negedge clk);
    set_idle(); muldiv_done = 1'b1;
    #1 chk("md_done_out", 16'(outs), 16'(P_NONE));
    @(negedge clk);
    set_idle();
    #1 chk("md_end_state", 16'(ctrl_state), 16'(S_RUN));
    chk("md_stallcnt", 16'(stall_cycles), 16'd4);

    // Memory wait interrupting a multiply/divide wait.
    do_reset(1'b0);
    @(negedge clk);
    set_idle(); ex_muldiv_start = 1'b1;
    #1 chk("mdm_start_out", 16'(outs), 16'(P_MD));
    @(negedge clk);
    set_idle();
    #1 chk("mdm_wait_state", 16'(ctrl_state), 16'(S_MD));
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      set_idle(); mem_req = 1'b1;
      #1 chk($sformatf("mdm_mem%0d_out", k), 16'(outs), 16'(P_MEM));
    end
    chk("mdm_mem_state", 16'(ctrl_state), 16'(S_MEM));
    @(negedge clk);
    set_idle();
    #1 chk("mdm_resume_out", 16'(outs), 16'(P_MD));
    @(negedge clk);
    set_idle();
    #1 chk("mdm_resume_state", 16'(ctrl_state), 16'(S_MD));
    @(negedge clk);
    set_idle(); muldiv_done = 1'b1;
    #1 chk("mdm_done_out", 16'(outs), 16'(P_NONE));
    @(negedge clk);
    set_idle();
    #1 chk("mdm_end_state", 16'(ctrl_state), 16'(S_RUN));

    // Redirect held back by a memory stall.
    do_reset(1'b0);
    @(negedge clk);
    set_idle(); ex_redirect = 1'b1; mem_req = 1'b1;
    #1 chk("rdm_blocked", 16'(outs), 16'(P_MEM));
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("rdm_flush", 16'(outs), 16'(P_RD));

    // stall_cycles saturates at all-ones (4-bit instance) and timeout stays set.
    do_reset(1'b0);
    repeat (20) begin
      @(negedge clk);
      set_idle(); mem_req = 1'b1;
    end
    @(negedge clk);
    set_idle();
    #1 chk("stall_sat", 16'(stall_cycles), 16'd15);
    chk("tmo_sticky", 16'(mem_timeout), 16'd1);

    // Timeout after four wait cycles, then asynchronous reset mid-MEM_WAIT.
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      set_idle(); mem_req = 1'b1;
      #1 chk($sformatf("tmo%0d", k), 16'(mem_timeout), (k >= 4) ? 16'd1 : 16'd0);
      chk($sformatf("tmo%0d_out", k), 16'(outs), 16'(P_MEM));
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_mem_state", 16'(ctrl_state), 16'(S_RUN));
    chk("arst_mem_tmo", 16'(mem_timeout), 16'd0);
    chk("arst_mem_stallcnt", 16'(stall_cycles), 16'd0);
    chk("arst_mem_outs", 16'(outs), 16'(P_NONE));
    // First edge after release evaluates normally.
    @(negedge clk);
    set_idle(); mem_req = 1'b1; rst = 1'b0;
    #1 chk("post_rst_out", 16'(outs), 16'(P_MEM));
    @(negedge clk);
    set_idle();
    #1 chk("post_rst_state", 16'(ctrl_state), 16'(S_MEM));
    chk("post_rst_stallcnt", 16'(stall_cycles), 16'd1);

    // Asynchronous reset mid-MULDIV_WAIT clears the in-flight operation.
    @(negedge clk);
    set_idle(); ex_muldiv_start = 1'b1;
    @(negedge clk);
    set_idle();
    #1 chk("arst_md_pre", 16'(ctrl_state), 16'(S_MD));
    #1 rst = 1'b1;
    #1 chk("arst_md_state", 16'(ctrl_state), 16'(S_RUN));
    chk("arst_md_outs", 16'(outs), 16'(P_NONE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("arst_md_after_outs", 16'(outs), 16'(P_NONE));
    chk("arst_md_after_state", 16'(ctrl_state), 16'(S_RUN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
